// File: rtl/seq_chunk_add_ctrl_if.sv
// rtl/seq_chunk_add_ctrl_if.sv - request/result bundle for the chunked sequential adder
// Optional ovf signal exists only when SEQ_CHUNK_ADD_OVF_EN is defined.
interface seq_chunk_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SEQ_CHUNK_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/seq_chunk_add_ctrl.sv
// rtl/seq_chunk_add_ctrl.sv - WIDTH-bit adder built from one SIZE-bit slice, one chunk per clock
// Optional signed-overflow output enabled by SEQ_CHUNK_ADD_OVF_EN.
module seq_chunk_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_chunk_add_ctrl_if.slave bus
);

  localparam int NCHUNK = WIDTH / SIZE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [SIZE:0]    slice_d;
  logic [WIDTH-1:0] part_d;

  assign slice_d = {1'b0, a_q[SIZE-1:0]} + {1'b0, b_q[SIZE-1:0]} + {{SIZE{1'b0}}, carry_q};

  // partial including the chunk being produced this cycle, so the last chunk lands in sum
  always_comb begin
    part_d = part_q;
    part_d[cnt_q*SIZE +: SIZE] = slice_d[SIZE-1:0];
  end

`ifdef SEQ_CHUNK_ADD_OVF_EN
  logic ovf_q;
  logic msb_cin_d;
  // carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c
  assign msb_cin_d = a_q[SIZE-1] ^ b_q[SIZE-1] ^ slice_d[SIZE-1];
  assign bus.ovf   = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_CHUNK_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            part_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          part_q  <= part_d;
          carry_q <= slice_d[SIZE];
          a_q     <= a_q >> SIZE;
          b_q     <= b_q >> SIZE;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= part_d;
            cout_q  <= slice_d[SIZE];
`ifdef SEQ_CHUNK_ADD_OVF_EN
            ovf_q   <= msb_cin_d ^ slice_d[SIZE];
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
